// File: rtl/dma_defs.sv
// Shared definitions for the DMA client-port scheduler: state encoding, field widths,
// requester indices and the request field bundle.
package dma_defs;

  localparam int unsigned DMA_AW = 21;
  localparam int unsigned DMA_DW = 16;
  localparam int unsigned DMA_BW = 2;

  localparam logic RQ_SD  = 1'b0;
  localparam logic RQ_IDE = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn0  = 2'd1,
    StOwn1  = 2'd2,
    StDrain = 2'd3
  } state_e;

  typedef struct packed {
    logic              rnw;
    logic [DMA_AW-1:0] addr;
    logic [DMA_DW-1:0] wrdata;
    logic [DMA_BW-1:0] bsel;
  } dma_fields_t;

endpackage

// File: rtl/dma_mux2.sv
// Field mux of the two requester bundles onto the DMA port; drives zero when nobody owns
// the slot.
module dma_mux2
  import dma_defs::*;
(
  input  logic        en_i,
  input  logic        sel_i,
  input  dma_fields_t r0_i,
  input  dma_fields_t r1_i,
  output dma_fields_t out_o
);

  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o = sel_i ? r1_i : r0_i;
    end
  end

endmodule

// File: rtl/dma_sched.sv
// Round-robin scheduler sharing the DRAM arbiter's DMA slot between the SD and IDE engines,
// with a per-grant burst cap and routing of the single outstanding read back to its issuer.
module dma_sched
  import dma_defs::*;
#(
  parameter int unsigned BURST = 8
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic              r0_rnw,
  input  logic              r1_rnw,
  input  logic [DMA_AW-1:0] r0_addr,
  input  logic [DMA_AW-1:0] r1_addr,
  input  logic [DMA_DW-1:0] r0_wrdata,
  input  logic [DMA_DW-1:0] r1_wrdata,
  input  logic [DMA_BW-1:0] r0_bsel,
  input  logic [DMA_BW-1:0] r1_bsel,
  output logic              r0_ack,
  output logic              r1_ack,
  output logic              r0_rdstb,
  output logic              r1_rdstb,
  output logic [DMA_DW-1:0] rddata,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [DMA_AW-1:0] dma_addr,
  output logic [DMA_DW-1:0] dma_wrdata,
  output logic [DMA_BW-1:0] dma_bsel,
  input  logic              dma_next,
  input  logic              dma_strobe,
  input  logic [DMA_DW-1:0] dma_rddata
);

  localparam logic [7:0] BurstCnt = 8'(BURST);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  logic        own, own_sel, sel_req, oth_req, cap_hit, accept, rd_ret, grant;
  dma_fields_t fields;

  assign own     = (state_q == StOwn0) || (state_q == StOwn1);
  assign own_sel = (state_q == StOwn1);
  assign sel_req = own_sel ? r1_req : r0_req;
  assign oth_req = own_sel ? r0_req : r1_req;
  // Once the cap is reached with the other side waiting, no further accept in this grant.
  assign cap_hit = (bcnt_q == BurstCnt) && oth_req;

  assign dma_req = own && sel_req && !rd_pend_q && !cap_hit;
  assign accept  = dma_req && dma_next;
  assign r0_ack  = accept && (own_sel == RQ_SD);
  assign r1_ack  = accept && (own_sel == RQ_IDE);

  assign rd_ret   = dma_strobe && rd_pend_q;
  assign r0_rdstb = rd_ret && (rd_owner_q == RQ_SD);
  assign r1_rdstb = rd_ret && (rd_owner_q == RQ_IDE);
  assign rddata   = dma_rddata;

  dma_mux2 u_mux (
    .en_i  (own),
    .sel_i (own_sel),
    .r0_i  ('{rnw: r0_rnw, addr: r0_addr, wrdata: r0_wrdata, bsel: r0_bsel}),
    .r1_i  ('{rnw: r1_rnw, addr: r1_addr, wrdata: r1_wrdata, bsel: r1_bsel}),
    .out_o (fields)
  );

  assign dma_rnw    = fields.rnw;
  assign dma_addr   = fields.addr;
  assign dma_wrdata = fields.wrdata;
  assign dma_bsel   = fields.bsel;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    bcnt_d     = bcnt_q;
    rd_pend_d  = rd_pend_q;
    rd_owner_d = rd_owner_q;
    grant      = 1'b0;

    if (rd_ret) begin
      rd_pend_d = 1'b0;
    end
    // A read accepted alongside a strobe leaves a fresh read pending.
    if (accept) begin
      bcnt_d = (bcnt_q == BurstCnt) ? bcnt_q : bcnt_q + 8'd1;
      if (dma_rnw) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = own_sel;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (r0_req || r1_req) begin
          grant   = (r0_req && r1_req) ? !last_q : r1_req;
          state_d = grant ? StOwn1 : StOwn0;
          last_d  = grant;
          bcnt_d  = '0;
        end
      end
      StOwn0, StOwn1: begin
        if (!sel_req || cap_hit) begin
          state_d = rd_pend_d ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (!rd_pend_q || rd_ret) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      bcnt_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      bcnt_q     <= bcnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_dma_sched.sv
// Directed scenarios followed by randomized traffic checked against a transaction-level model
// of the two requesters, the single outstanding read and the burst-fairness bound.
module tb_dma_sched;
  import dma_defs::*;

  localparam int unsigned BURST = 8;

  logic        fclk = 1'b0;
  logic        rst;
  logic        r0_req, r1_req, r0_rnw, r1_rnw;
  logic [20:0] r0_addr, r1_addr;
  logic [15:0] r0_wrdata, r1_wrdata;
  logic [1:0]  r0_bsel, r1_bsel;
  logic        r0_ack, r1_ack, r0_rdstb, r1_rdstb;
  logic [15:0] rddata;
  logic        dma_req, dma_rnw;
  logic [20:0] dma_addr;
  logic [15:0] dma_wrdata;
  logic [1:0]  dma_bsel;
  logic        dma_next, dma_strobe;
  logic [15:0] dma_rddata;

  always #5 fclk = ~fclk;

  dma_sched #(.BURST(BURST)) dut (
    .fclk       (fclk),
    .rst        (rst),
    .r0_req     (r0_req),
    .r1_req     (r1_req),
    .r0_rnw     (r0_rnw),
    .r1_rnw     (r1_rnw),
    .r0_addr    (r0_addr),
    .r1_addr    (r1_addr),
    .r0_wrdata  (r0_wrdata),
    .r1_wrdata  (r1_wrdata),
    .r0_bsel    (r0_bsel),
    .r1_bsel    (r1_bsel),
    .r0_ack     (r0_ack),
    .r1_ack     (r1_ack),
    .r0_rdstb   (r0_rdstb),
    .r1_rdstb   (r1_rdstb),
    .rddata     (rddata),
    .dma_req    (dma_req),
    .dma_rnw    (dma_rnw),
    .dma_addr   (dma_addr),
    .dma_wrdata (dma_wrdata),
    .dma_bsel   (dma_bsel),
    .dma_next   (dma_next),
    .dma_strobe (dma_strobe),
    .dma_rddata (dma_rddata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic smp();
    @(negedge fclk);
  endtask

  task automatic clear_inputs();
    r0_req = 0; r1_req = 0; r0_rnw = 0; r1_rnw = 0;
    r0_addr = '0; r1_addr = '0; r0_wrdata = '0; r1_wrdata = '0;
    r0_bsel = '0; r1_bsel = '0;
    dma_next = 0; dma_strobe = 0; dma_rddata = '0;
  endtask

  task automatic settle();
    clear_inputs();
    repeat (3) tick();
  endtask

  // Randomized-phase model state
  logic        act[2];
  logic        rnw_v[2];
  logic [20:0] addr_v[2];
  logic [15:0] data_v[2];
  logic [1:0]  bsel_v[2];
  int          wait_cyc[2];
  int          other_acks[2];
  logic        pend, stb, gen, ackx;
  int          powner, pdelay, g;

  task automatic apply_req();
    r0_req = act[0]; r0_rnw = rnw_v[0]; r0_addr = addr_v[0];
    r0_wrdata = data_v[0]; r0_bsel = bsel_v[0];
    r1_req = act[1]; r1_rnw = rnw_v[1]; r1_addr = addr_v[1];
    r1_wrdata = data_v[1]; r1_bsel = bsel_v[1];
  endtask

  initial begin
    int prev, run, switches, first, n0, n1;

    // Reset state
    rst = 1;
    clear_inputs();
    tick();
    tick();
    smp();
    chk("rst_dma_req", dma_req, 0);
    chk("rst_acks", {r1_ack, r0_ack}, 0);
    chk("rst_rdstb", {r1_rdstb, r0_rdstb}, 0);
    chk("rst_fields", {dma_rnw, dma_addr, dma_wrdata, dma_bsel}, 0);
    tick();
    rst = 0;

    // Tie from reset: r0 first, r1 after a single idle cycle
    tick();
    r0_req = 1; r0_addr = 21'h00AAA; r1_req = 1; r1_addr = 21'h1BBBB;
    smp();
    chk("tie_idle_req", dma_req, 0);
    tick();
    smp();
    chk("tie_req0", dma_req, 1);
    chk("tie_addr0", dma_addr, 21'h00AAA);
    chk("tie_noack", r0_ack, 0);
    tick();
    dma_next = 1;
    smp();
    chk("tie_ack0", {r1_ack, r0_ack}, 2'b01);
    tick();
    r0_req = 0; dma_next = 0;
    smp();
    chk("tie_drop_req", dma_req, 0);
    tick();
    smp();
    chk("tie_gap", dma_req, 0);
    tick();
    smp();
    chk("tie_req1", dma_req, 1);
    chk("tie_addr1", dma_addr, 21'h1BBBB);
    tick();
    dma_next = 1;
    smp();
    chk("tie_ack1", {r1_ack, r0_ack}, 2'b10);
    tick();
    settle();

    // Single writer: 4 consecutive accepts
    r0_req = 1; r0_addr = 21'h00400; r0_wrdata = 16'hA000; r0_bsel = 2'b11; dma_next = 1;
    smp();
    chk("sw_first_noack", r0_ack, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      r0_addr = 21'h00400 + 21'(k);
      r0_wrdata = 16'hA000 + 16'(k);
      smp();
      chk("sw_ack", r0_ack, 1);
      chk("sw_addr", dma_addr, 21'h00400 + 21'(k));
      chk("sw_wrdata", dma_wrdata, 16'hA000 + 16'(k));
      chk("sw_no_r1", {r1_ack, r1_rdstb}, 0);
    end
    tick();
    settle();

    // Read ordering: r1 read, strobe held off for 5 cycles
    r1_req = 1; r1_rnw = 1; r1_addr = 21'h10C00; dma_next = 1;
    smp();
    chk("rd_idle", dma_req, 0);
    tick();
    smp();
    chk("rd_ack", r1_ack, 1);
    chk("rd_rnw", dma_rnw, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      r1_rnw = 0; r1_addr = 21'h10C01; r1_wrdata = 16'h1234;
      smp();
      chk("rd_hold", {dma_req, r1_ack, r1_rdstb}, 0);
    end
    tick();
    dma_strobe = 1; dma_rddata = 16'hBEEF;
    smp();
    chk("rd_stb", {r1_rdstb, r0_rdstb}, 2'b10);
    chk("rd_data", rddata, 16'hBEEF);
    chk("rd_stb_req", dma_req, 0);
    tick();
    dma_strobe = 0;
    smp();
    chk("rd_next_req", dma_req, 1);
    chk("rd_next_ack", r1_ack, 1);
    chk("rd_next_addr", dma_addr, 21'h10C01);
    tick();
    settle();

    // Release into DRAIN: r0 read, r0 drops, r1 waits for the strobe
    r0_req = 1; r0_rnw = 1; r0_addr = 21'h00E00; dma_next = 1;
    smp();
    tick();
    smp();
    chk("dr_ack0", r0_ack, 1);
    tick();
    r0_req = 0; r1_req = 1; r1_rnw = 0; r1_addr = 21'h10F00;
    smp();
    chk("dr_rel", dma_req, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      smp();
      chk("dr_drain", {dma_req, r1_ack}, 0);
    end
    tick();
    dma_strobe = 1; dma_rddata = 16'h5A5A;
    smp();
    chk("dr_stb", {r1_rdstb, r0_rdstb}, 2'b01);
    chk("dr_data", rddata, 16'h5A5A);
    tick();
    dma_strobe = 0;
    smp();
    chk("dr_idle", dma_req, 0);
    tick();
    smp();
    chk("dr_grant1", {dma_req, r1_ack}, 2'b11);
    chk("dr_addr1", dma_addr, 21'h10F00);
    tick();
    clear_inputs();
    tick();
    dma_strobe = 1; dma_rddata = 16'h1111;
    smp();
    chk("spurious_stb", {r1_rdstb, r0_rdstb}, 0);
    tick();
    settle();

    // Reset mid-read
    r0_req = 1; r0_rnw = 1; r0_addr = 21'h00123; dma_next = 1;
    smp();
    tick();
    smp();
    chk("rmr_ack", r0_ack, 1);
    tick();
    r0_req = 0; dma_next = 0; rst = 1;
    smp();
    tick();
    rst = 0;
    smp();
    chk("rmr_outs", {dma_req, r0_ack, r1_ack, r0_rdstb, r1_rdstb, rddata}, 0);
    chk("rmr_fields", {dma_rnw, dma_addr, dma_wrdata, dma_bsel}, 0);
    tick();
    dma_strobe = 1; dma_rddata = 16'h7777;
    smp();
    chk("rmr_late_stb", {r1_rdstb, r0_rdstb}, 0);
    tick();
    settle();

    // Burst cap: both stream writes; runs of exactly BURST accepts alternate
    prev = -1; run = 0; switches = 0; first = -1; n0 = 0; n1 = 0;
    r0_req = 1; r1_req = 1; dma_next = 1;
    for (int c = 0; c < 70; c++) begin
      r0_addr = 21'h00100 + 21'(n0);
      r1_addr = 21'h10200 + 21'(n1);
      smp();
      if (r0_ack || r1_ack) begin
        g = int'(r1_ack);
        if (first < 0) first = g;
        if (prev >= 0 && g != prev) begin
          chk("burst_run", run, BURST);
          switches++;
          run = 0;
        end
        prev = g;
        run++;
        chk("burst_max", run <= BURST, 1);
        if (r0_ack) n0++;
        if (r1_ack) n1++;
      end
      tick();
    end
    chk("burst_first", first, 0);
    chk("burst_switches", switches >= 4, 1);
    settle();

    // Randomized traffic against the transaction-level model
    rst = 1;
    tick();
    rst = 0;
    for (int x = 0; x < 2; x++) begin
      act[x] = 0; rnw_v[x] = 0; addr_v[x] = '0; data_v[x] = '0; bsel_v[x] = '0;
      wait_cyc[x] = 0; other_acks[x] = 0;
    end
    pend = 0; powner = 0; pdelay = 0; stb = 0;
    for (int c = 0; c < 3500; c++) begin
      gen = (c < 3000);
      if (!gen && !act[0] && !act[1] && !pend) break;
      tick();
      for (int x = 0; x < 2; x++) begin
        if (!act[x] && gen && $urandom_range(0, 3) != 0) begin
          act[x]      = 1;
          rnw_v[x]    = 1'($urandom_range(0, 1));
          addr_v[x]   = {x[0], 20'($urandom)};
          data_v[x]   = 16'($urandom);
          bsel_v[x]   = 2'($urandom);
          wait_cyc[x] = 0;
          other_acks[x] = 0;
        end
      end
      apply_req();
      dma_next = ($urandom_range(0, 3) != 0);
      if (pend) begin
        if (pdelay == 0) stb = 1;
        else begin
          stb = 0;
          pdelay--;
        end
      end else begin
        stb = ($urandom_range(0, 7) == 0);
      end
      dma_strobe = stb;
      dma_rddata = 16'($urandom);
      smp();
      chk("rnd_rdstb0", r0_rdstb, stb && pend && powner == 0);
      chk("rnd_rdstb1", r1_rdstb, stb && pend && powner == 1);
      chk("rnd_rddata", rddata, dma_rddata);
      if (pend) chk("rnd_req_while_pend", dma_req, 0);
      if (dma_req) begin
        g = int'(dma_addr[20]);
        chk("rnd_grant_has_req", act[g], 1);
        chk("rnd_fields", {dma_rnw, dma_addr, dma_wrdata, dma_bsel},
            {rnw_v[g], addr_v[g], data_v[g], bsel_v[g]});
        chk("rnd_ack_granted", (g == 1) ? r1_ack : r0_ack, dma_next);
        chk("rnd_ack_other", (g == 1) ? r0_ack : r1_ack, 0);
      end else begin
        chk("rnd_ack_idle", {r1_ack, r0_ack}, 0);
      end
      if (stb && pend) pend = 0;
      for (int x = 0; x < 2; x++) begin
        ackx = (x == 1) ? r1_ack : r0_ack;
        if (ackx && act[x]) begin
          act[x] = 0;
          chk("rnd_wait_bound", wait_cyc[x] < 300, 1);
          if (rnw_v[x]) begin
            pend = 1;
            powner = x;
            pdelay = $urandom_range(0, 4);
          end
          if (act[1-x]) begin
            other_acks[1-x]++;
            chk("rnd_burst_cap", other_acks[1-x] <= BURST, 1);
          end
        end else if (act[x]) begin
          wait_cyc[x]++;
        end
      end
    end
    chk("rnd_drained", {act[0], act[1], pend}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_sched.md
# dma_sched

Two-requester scheduler for the DRAM arbiter's DMA client port, in the `fclk` domain. Shares the single DMA slot between the SD-card DMA engine (requester 0) and the IDE DMA engine (requester 1). It grants round-robin with a per-grant burst cap. It tracks the one outstanding read so each read strobe returns to the requester that issued it. It sits between the two engines and `arbiter`, alongside the existing CPU and video clients.

## Interface
Parameters:
- `BURST`, 8: maximum accepted cycles per grant while the other requester is waiting (1..255).

Ports:
- `fclk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `r0_req`, `r1_req` in 1: request. Held with stable fields until acked.
- `r0_rnw`, `r1_rnw` in 1: 1 = read, 0 = write.
- `r0_addr`, `r1_addr` in 21: word address.
- `r0_wrdata`, `r1_wrdata` in 16: write data.
- `r0_bsel`, `r1_bsel` in 2: byte select for writes.
- `r0_ack`, `r1_ack` out 1: one-cycle pulse when the request is accepted.
- `r0_rdstb`, `r1_rdstb` out 1: one-cycle pulse when read data is valid on `rddata`.
- `rddata` out 16: copy of `dma_rddata`.
- `dma_req` out 1: request to `arbiter`.
- `dma_rnw` out 1: read/write to `arbiter`.
- `dma_addr` out 21: address to `arbiter`.
- `dma_wrdata` out 16: write data to `arbiter`.
- `dma_bsel` out 2: byte select to `arbiter`.
- `dma_next` in 1: `arbiter` takes the presented request this cycle.
- `dma_strobe` in 1: read data valid on `dma_rddata`.
- `dma_rddata` in 16: read data from `arbiter`.

## Operation
- States: `IDLE`, `OWN0`, `OWN1`, `DRAIN`.
- `IDLE`:
  - Only one request set: go to the matching `OWNx`.
  - Both set: go to `OWNx` where x ≠ `last`. `last` resets to 1, so requester 0 wins the first tie.
  - Entering `OWNx` clears `bcnt` and sets `last` to x.
- `OWNx`:
  - `dma_req` = `rx_req` and no read is outstanding. The other `dma_*` fields mux from requester x.
  - On `dma_next`: pulse `rx_ack`, increment `bcnt`. If `rnw` = 1, set `rd_pend` and `rd_owner` = x.
  - Release when `rx_req` = 0, or when `bcnt` = `BURST` and the other requester is set.
  - On release: go to `DRAIN` if `rd_pend`, otherwise `IDLE`.
- `DRAIN`: `dma_req` = 0. Go to `IDLE` on the `dma_strobe` that clears `rd_pend`.
- Read return:
  - On `dma_strobe` with `rd_pend` set: pulse `r[rd_owner]_rdstb`, clear `rd_pend`.
  - `dma_strobe` without `rd_pend` is ignored; no strobe is forwarded.
- At most one read is outstanding. A new request (read or write) is not presented until the strobe for the current read arrives. This keeps writes ordered after reads.
- `bcnt` is 8 bits and saturates at `BURST`. It never wraps.
- Withdrawing `req` before ack is illegal. The block need not handle it, but must not hang: it releases on `req` = 0.

## Timing
- Reset values: state `IDLE`; `last` = 1; `bcnt` = 0; `rd_pend` = 0; `dma_req`, `r*_ack`, `r*_rdstb` = 0; `dma_*` fields = 0.
- Request to `dma_req`: 1 cycle. The grant is registered, so `dma_req` first rises the cycle after `req` is seen in `IDLE`.
- `r*_ack` = `dma_next` & `dma_req` & (state == `OWNx`). It is combinational, in the same cycle as `dma_next`.
- `r*_rdstb` and `rddata` are combinational from `dma_strobe` and `dma_rddata`, same cycle.
- Back-to-back writes: one accept per cycle while `dma_next` is held.
- Back-to-back reads: `dma_req` drops from the cycle after accept until the cycle after the strobe.
- Grant switch costs 1 idle cycle (`OWNx` → `IDLE` → `OWNy`).
- Strobe and next in the same cycle in `OWNx`: clearing the old `rd_pend` and setting it for the new read are both legal. Set wins.
- `rst` in any state aborts any pending read: `rd_pend` clears, and a late `dma_strobe` is not forwarded.

## Structure
- Shared package (`dma_defs`) holds:
  - State encoding (2 bits).
  - `DMA_AW` = 21, `DMA_DW` = 16, `DMA_BW` = 2.
  - Requester index constants `RQ_SD` = 0, `RQ_IDE` = 1.
- One sub-module, `dma_mux2`: purely combinational field mux of request bundles by grant. Keeps the FSM file free of wide muxing.
- Everything else stays flat in `dma_sched`.

## Test plan
- Reset mid-read: r0 read accepted, `rst` asserted before the strobe → all outputs 0 next cycle; a later `dma_strobe` produces no `r0_rdstb`.
- Single writer: r0 writes 4 words with `dma_next` always 1 → 4 consecutive `r0_ack`; `dma_addr` follows r0; no r1 activity.
- Tie and round-robin: both request from reset → r0 granted first; after r0 drops, r1 granted after exactly 1 idle cycle.
- Burst cap with `BURST` = 8: both stream writes continuously → grant alternates after every 8 acks; `bcnt` never exceeds 8.
- Read ordering: r1 read accepted, `dma_strobe` delayed 5 cycles → `dma_req` stays 0 until the strobe; `r1_rdstb` fires with `rddata` = `dma_rddata`; the next request is presented 1 cycle later.
- Release into `DRAIN`: r0 read accepted, r0 then drops `req` while r1 requests → `DRAIN` until the strobe, `r0_rdstb` fires, then r1 is granted. No `r1_rdstb` for r0's data.
